// File: rtl/sram_ctrl.sv
// Host-side initiator for the 8-bit asynchronous sram: turns single-beat valid/ready
// requests into chip-select / strobe pin cycles with programmable setup, strobe and hold.
module sram_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int SETUP  = 1,
  parameter int STROBE = 2,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout,
  output logic              sram_wr,
  output logic              sram_rd,
  output logic              sram_cs
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

  localparam logic [3:0] SETUP_LD  = 4'(SETUP - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE - 1);
  localparam logic [3:0] HOLD_LD   = 4'(HOLD - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       we_q;

  // Every pin and response output is a flop; sram_rd idles high because it is active-low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      sram_addr <= '0;
      sram_din  <= '0;
      sram_wr   <= 1'b0;
      sram_rd   <= 1'b1;
      sram_cs   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            sram_addr <= req_addr;
            sram_din  <= req_we ? req_wdata : '0;
            we_q      <= req_we;
            sram_cs   <= 1'b1;
            req_ready <= 1'b0;
            cnt       <= SETUP_LD;
            state     <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == 4'd0) begin
            if (we_q) sram_wr <= 1'b1;
            else      sram_rd <= 1'b0;
            cnt   <= STROBE_LD;
            state <= ST_STROBE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_STROBE: begin
          // Read data is sampled on the same edge that releases the strobe.
          if (cnt == 4'd0) begin
            sram_wr   <= 1'b0;
            sram_rd   <= 1'b1;
            if (!we_q) rsp_rdata <= sram_dout;
            rsp_valid <= 1'b1;
            cnt       <= HOLD_LD;
            state     <= ST_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (cnt == 4'd0) begin
            sram_cs   <= 1'b0;
            sram_din  <= '0;
            req_ready <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
          sram_cs   <= 1'b0;
          sram_wr   <= 1'b0;
          sram_rd   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: two instances (default 1/2/1 and 3/1/2 timing),
// each driving a behavioural sram, with a response scoreboard and per-cycle pin checks.
module tb_sram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] req_valid, req_ready, req_we, rsp_valid, sram_wr, sram_rd, sram_cs;
  logic [7:0] req_addr [2];
  logic [7:0] req_wdata [2];
  logic [7:0] rsp_rdata [2];
  logic [7:0] sram_addr [2];
  logic [7:0] sram_din [2];
  logic [7:0] sram_dout [2];

  logic [7:0] mem [2][256];
  logic [7:0] mdl [2][256];
  logic [7:0] lastRdata [2];
  logic [7:0] expq [$];

  int checks = 0;
  int failures = 0;

  sram_ctrl #(.ADDR_W(8), .DATA_W(8), .SETUP(1), .STROBE(2), .HOLD(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_addr(sram_addr[0]), .sram_din(sram_din[0]), .sram_dout(sram_dout[0]),
    .sram_wr(sram_wr[0]), .sram_rd(sram_rd[0]), .sram_cs(sram_cs[0])
  );

  sram_ctrl #(.ADDR_W(8), .DATA_W(8), .SETUP(3), .STROBE(1), .HOLD(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_addr(sram_addr[1]), .sram_din(sram_din[1]), .sram_dout(sram_dout[1]),
    .sram_wr(sram_wr[1]), .sram_rd(sram_rd[1]), .sram_cs(sram_cs[1])
  );

  // Behavioural sram: writes while cs and wr are high, drives data while cs and rd low.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (sram_cs[d] && sram_wr[d]) mem[d][sram_addr[d]] = sram_din[d];
  end

  always_comb begin
    for (int d = 0; d < 2; d++)
      sram_dout[d] = (sram_cs[d] && !sram_rd[d]) ? mem[d][sram_addr[d]] : 8'h00;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard consumer: every response pops the value predicted at accept time.
  always @(negedge clk) begin
    int d;
    logic [7:0] exp;
    if (rst_n && (rsp_valid != 2'b00)) begin
      d = rsp_valid[1] ? 1 : 0;
      if (expq.size() == 0) begin
        checkOutput("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        exp = expq.pop_front();
        checkOutput("rsp_rdata", rsp_rdata[d], exp);
      end
    end
  end

  task automatic applyStimulus(input int d, input logic we, input logic [7:0] a,
                               input logic [7:0] wd, input bit keep, input bit scramble,
                               output longint acceptTime);
    int s, t, h, tot;
    logic [7:0] expDin;
    s = (d == 1) ? 3 : 1;
    t = (d == 1) ? 1 : 2;
    h = (d == 1) ? 2 : 1;
    tot = s + t + h;
    acceptTime = 0;
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    for (int i = 0; i < 20 && !req_ready[d]; i++) @(negedge clk);
    if (!req_ready[d]) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    acceptTime = $time;
    if (we) begin
      mdl[d][a] = wd;
      expq.push_back(lastRdata[d]);
    end else begin
      expq.push_back(mdl[d][a]);
      lastRdata[d] = mdl[d][a];
    end
    expDin = we ? wd : 8'h00;
    for (int n = 0; n <= tot; n++) begin
      @(negedge clk);
      if (n == 0 && !keep) req_valid[d] = 1'b0;
      checkOutput("sram_cs",   sram_cs[d],   32'(n < tot));
      checkOutput("sram_wr",   sram_wr[d],   32'(we && n >= s && n < s + t));
      checkOutput("sram_rd",   sram_rd[d],   32'(!(!we && n >= s && n < s + t)));
      checkOutput("sram_addr", sram_addr[d], a);
      checkOutput("sram_din",  sram_din[d],  (n < tot) ? expDin : 8'h00);
      checkOutput("rsp_valid", rsp_valid[d], 32'(n == s + t));
      checkOutput("req_ready", req_ready[d], 32'(n == tot));
      if (scramble) begin
        req_addr[d]  = 8'($urandom);
        req_wdata[d] = 8'($urandom);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired t=%0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    longint ta, tb, tc, tx;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        mem[d][i] = 8'h00;
        mdl[d][i] = 8'h00;
      end
      lastRdata[d] = 8'h00;
      req_addr[d]  = 8'h00;
      req_wdata[d] = 8'h00;
    end
    req_valid = 2'b00;
    req_we    = 2'b00;

    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput("rst_req_ready", req_ready[d], 32'd1);
      checkOutput("rst_rsp_valid", rsp_valid[d], 32'd0);
      checkOutput("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      checkOutput("rst_sram_addr", sram_addr[d], 32'd0);
      checkOutput("rst_sram_din",  sram_din[d],  32'd0);
      checkOutput("rst_sram_wr",   sram_wr[d],   32'd0);
      checkOutput("rst_sram_rd",   sram_rd[d],   32'd1);
      checkOutput("rst_sram_cs",   sram_cs[d],   32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] single write and read-back");
    applyStimulus(0, 1'b1, 8'hCA, 8'hB5, 1'b0, 1'b0, tx);
    applyStimulus(0, 1'b0, 8'hCA, 8'h00, 1'b0, 1'b0, tx);

    $display("[TB] back-to-back writes with req_valid held");
    applyStimulus(0, 1'b1, 8'h00, 8'h11, 1'b1, 1'b0, ta);
    applyStimulus(0, 1'b1, 8'hFF, 8'h22, 1'b1, 1'b0, tb);
    applyStimulus(0, 1'b1, 8'h01, 8'h33, 1'b0, 1'b0, tc);
    checkOutput("b2b_gap1", 32'(tb - ta), 32'd50);
    checkOutput("b2b_gap2", 32'(tc - tb), 32'd50);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, tx);
    applyStimulus(0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, tx);
    applyStimulus(0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, tx);

    $display("[TB] parameter sweep 3/1/2");
    applyStimulus(1, 1'b1, 8'h5A, 8'hC3, 1'b0, 1'b0, tx);
    applyStimulus(1, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b0, tx);

    $display("[TB] reset during strobe");
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0]  = 8'h10;
    req_wdata[0] = 8'hAA;
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("pre_reset_wr", sram_wr[0], 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_wr",        sram_wr[0],   32'd0);
    checkOutput("mid_rst_rd",        sram_rd[0],   32'd1);
    checkOutput("mid_rst_cs",        sram_cs[0],   32'd0);
    checkOutput("mid_rst_ready",     req_ready[0], 32'd1);
    checkOutput("mid_rst_rsp_valid", rsp_valid[0], 32'd0);
    checkOutput("mid_rst_addr",      sram_addr[0], 32'd0);
    checkOutput("mid_rst_rdata",     rsp_rdata[0], 32'd0);
    lastRdata[0] = 8'h00;
    lastRdata[1] = 8'h00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, tx);

    $display("[TB] request fields changing while busy");
    applyStimulus(0, 1'b1, 8'h77, 8'hE1, 1'b0, 1'b1, tx);
    applyStimulus(0, 1'b0, 8'h77, 8'h00, 1'b0, 1'b1, tx);
    applyStimulus(1, 1'b0, 8'h5A, 8'h00, 1'b0, 1'b1, tx);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Sequential initiator for the 8-bit asynchronous `sram` block: it turns single-beat host read/write requests into correctly timed SRAM pin cycles with chip select, strobe, setup and hold. It is the driver end of the `sram` pin interface (`dout`, `din`, `addr`, `wr`, `rd`, `cs`), so the memory no longer has to be exercised directly by testbench waveforms. It sits between a host request port (valid/ready) and one `sram` instance.

## Interface
- `ADDR_W`, 8: address width.
- `DATA_W`, 8: data width.
- `SETUP`, 1: cycles from address/data valid to strobe assert; range 1..15.
- `STROBE`, 2: cycles the strobe is held asserted; range 1..15.
- `HOLD`, 1: cycles address/data are held after the strobe drops; range 1..15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  1  host request present.
- `req_ready`  out  1  controller idle and able to accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  request address.
- `req_wdata`  in  DATA_W  write data.
- `rsp_valid`  out  1  one-cycle completion pulse, for both reads and writes.
- `rsp_rdata`  out  DATA_W  read data; valid when `rsp_valid` is 1 after a read.
- `sram_addr`  out  ADDR_W  to `sram` `addr`.
- `sram_din`  out  DATA_W  to `sram` `din`.
- `sram_dout`  in  DATA_W  from `sram` `dout`.
- `sram_wr`  out  1  write strobe, active-high; to `sram` `wr`.
- `sram_rd`  out  1  read strobe, active-low; to `sram` `rd`.
- `sram_cs`  out  1  chip select, active-high; to `sram` `cs`.

## Operation
- **Reset values:**
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0.
  - `sram_addr` = 0, `sram_din` = 0.
  - `sram_wr` = 0, `sram_rd` = 1, `sram_cs` = 0.
  - State = IDLE, counter = 0.
- **FSM states:** IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter times each non-IDLE state.
- **IDLE:**
  - `req_ready` = 1, `sram_cs` = 0.
  - When `req_valid` is 1 at a rising edge, register `req_addr` into `sram_addr`.
  - Register `req_wdata` into `sram_din` for a write; set `sram_din` to 0 for a read.
  - Latch `req_we`, set `sram_cs` = 1, load counter with SETUP-1, and go to SETUP.
- **SETUP:**
  - Strobes stay inactive.
  - At count 0, load STROBE-1, go to STROBE, and assert the strobe: `sram_wr` = 1 for a write, `sram_rd` = 0 for a read.
- **STROBE:**
  - Strobe stays asserted.
  - At count 0:
    - Deassert the strobe.
    - For a read, capture `sram_dout` into `rsp_rdata`.
    - Set `rsp_valid` = 1, load HOLD-1, and go to HOLD.
- **HOLD:**
  - `rsp_valid` drops after one cycle.
  - `sram_addr`, `sram_din` and `sram_cs` stay unchanged.
  - At count 0, set `sram_cs` = 0 and `sram_din` = 0, then go to IDLE.
- **Outputs are registered:**
  - `sram_*` outputs, `rsp_*` and `req_ready` come straight from flops, with no combinational path from inputs.
  - `req_ready` = (state == IDLE).
- **Write handling:** writes leave `rsp_rdata` unchanged.
- **Ignored inputs:** `req_*` inputs are ignored outside IDLE, and request fields are sampled only on the accept edge.
- **Address width:** no address arithmetic; `sram_addr` is the accepted `req_addr` unmodified, full width.

## Timing
- **Cycle numbering:** accept edge = E0; "cycle n" = the interval after edge En.
- **Active window:**
  - `sram_cs` = 1 from cycle 0 through cycle SETUP+STROBE+HOLD-1.
  - Strobe is asserted from cycle SETUP through cycle SETUP+STROBE-1.
- **Read capture:** edge E(SETUP+STROBE), i.e. the same edge that deasserts the strobe, so data is sampled while the strobe is still active.
- **Response:** `rsp_valid` is high for exactly cycle SETUP+STROBE.
- **Return to idle:** `req_ready` returns to 1 in cycle SETUP+STROBE+HOLD.
- **Defaults (1/2/1):**
  - SETUP in cycle 0, strobe in cycles 1–2, capture at E3.
  - `rsp_valid` in cycle 3, `req_ready` again in cycle 4.
  - Earliest next accept is E5, giving a throughput of one request per SETUP+STROBE+HOLD+1 cycles.
- **Address/data stability:** `sram_addr` and `sram_din` never change while `sram_cs` = 1. Address and data are therefore stable for at least SETUP cycles before and HOLD cycles after every strobe.
- **Strobe exclusivity:** `sram_wr` and the active-low `sram_rd` are never both active.
- **Continuous `req_valid`:** back-to-back accepts occur, separated by one IDLE cycle.
- **Reset mid-operation:**
  - All outputs return immediately (asynchronously) to their reset values, including the strobes.
  - The in-flight request is dropped, and no `rsp_valid` is issued for it.
  - After reset release, the first rising edge with `req_valid` = 1 is accepted.

## Test plan
- **Single write:** reset, then write addr 0xCA data 0xB5 with defaults.
  - `sram_cs` = 1 in cycles 0–3.
  - `sram_wr` = 1 in cycles 1–2 only, with `sram_addr` = 0xCA and `sram_din` = 0xB5 stable in cycles 0–3.
  - `rsp_valid` pulses in cycle 3, and `req_ready` = 1 in cycle 4.
- **Read-back:** write 0xCA←0xB5, then read 0xCA.
  - `sram_rd` = 0 in cycles 1–2 of the read.
  - `rsp_valid` pulses with `rsp_rdata` = 0xB5.
  - `sram_din` = 0 throughout the read.
- **Back-to-back:** hold `req_valid` high for 3 writes (0x00←0x11, 0xFF←0x22, 0x01←0x33), then read all three.
  - Accepts occur at E0, E5, E10.
  - Reads return 0x11, 0x22, 0x33.
  - No strobe overlaps between transactions.
- **Parameter sweep:** SETUP = 3, STROBE = 1, HOLD = 2.
  - Strobe only in cycle 3, `rsp_valid` in cycle 4, `req_ready` in cycle 6.
  - The read returns the correct data.
- **Reset mid-strobe:** assert `rst_n` = 0 in cycle 1 of a write to 0x10←0xAA.
  - `sram_wr` = 0, `sram_rd` = 1 and `sram_cs` = 0 immediately.
  - No `rsp_valid` for the dropped write.
  - After release, a read of 0x10 completes normally.
- **Ignored request change:** change `req_addr`/`req_wdata` during SETUP/STROBE/HOLD.
  - `sram_addr` and `sram_din` are unchanged until the next accept.
